// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch unit: quick-compare selector encodings,
// FSM state encoding and the selector legality check.
package branch_unit_pkg;

    localparam int SEL_W = 6;

    localparam logic [SEL_W-1:0] SELECT_QC_EQ  = 6'h01;
    localparam logic [SEL_W-1:0] SELECT_QC_NE  = 6'h02;
    localparam logic [SEL_W-1:0] SELECT_QC_LEZ = 6'h04;
    localparam logic [SEL_W-1:0] SELECT_QC_GTZ = 6'h08;
    localparam logic [SEL_W-1:0] SELECT_QC_LTZ = 6'h10;
    localparam logic [SEL_W-1:0] SELECT_QC_GEZ = 6'h20;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SLOT     = 2'd1,
        ST_REDIRECT = 2'd2
    } br_state_e;

    function automatic logic sel_defined(input logic [SEL_W-1:0] sel);
        logic ok;
        case (sel)
            SELECT_QC_EQ, SELECT_QC_NE, SELECT_QC_LEZ,
            SELECT_QC_GTZ, SELECT_QC_LTZ, SELECT_QC_GEZ: ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/branch_unit_br_target_add.sv
// Branch target adder: pc + 4 + (sign-extended word offset << 2), wrapping mod 2^32.
module br_target_add (
    input  logic [31:0] pc,
    input  logic [15:0] offset,
    output logic [31:0] target
);

    assign target = pc + 32'd4 + {{14{offset[15]}}, offset, 2'b00};

endmodule

// File: rtl/branch_unit.sv
// Conditional branch resolution: EX register, one-cycle resolve, delay-slot
// sequencing FSM, redirect pulse, sticky error and saturating statistics.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             id_br_valid,
    input  logic [5:0]       id_br_sel,
    input  logic [31:0]      id_br_pc,
    input  logic [15:0]      id_br_offset,
    output logic [5:0]       qc_sel,
    input  logic             qc_result,
    input  logic             slot_issued,
    output logic             redirect_valid,
    output logic [31:0]      redirect_target,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] cnt_resolved,
    output logic [CNT_W-1:0] cnt_taken
);

    br_state_e        state_reg, state_next;
    logic             ex_valid_reg;
    logic [5:0]       ex_sel_reg;
    logic [31:0]      ex_pc_reg;
    logic [15:0]      ex_off_reg;
    logic [31:0]      target_reg;
    logic             err_reg;
    logic [CNT_W-1:0] cnt_resolved_reg, cnt_taken_reg;

    logic [31:0]      target_calc;
    logic             resolve, accept, in_slot_branch, sel_ok, taken;

    br_target_add u_target_add (
        .pc     (ex_pc_reg),
        .offset (ex_off_reg),
        .target (target_calc)
    );

    // Only a branch seen while IDLE is accepted; one arriving behind a taken
    // branch is sitting in its delay slot and gets dropped.
    assign resolve        = ex_valid_reg && !stall;
    assign accept         = resolve && (state_reg == ST_IDLE);
    assign in_slot_branch = resolve && (state_reg != ST_IDLE);
    assign sel_ok         = sel_defined(ex_sel_reg);
    assign taken          = accept && sel_ok && qc_result;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (taken) state_next = slot_issued ? ST_REDIRECT : ST_SLOT;
            ST_SLOT:     if (!stall && slot_issued) state_next = ST_REDIRECT;
            ST_REDIRECT: if (!stall) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_IDLE;
            ex_valid_reg     <= 1'b0;
            ex_sel_reg       <= SELECT_QC_NE;
            ex_pc_reg        <= '0;
            ex_off_reg       <= '0;
            target_reg       <= '0;
            err_reg          <= 1'b0;
            cnt_resolved_reg <= '0;
            cnt_taken_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (!stall) begin
                ex_valid_reg <= id_br_valid;
                if (id_br_valid) begin
                    ex_sel_reg <= id_br_sel;
                    ex_pc_reg  <= id_br_pc;
                    ex_off_reg <= id_br_offset;
                end
            end
            // Target only loads on a taken accept so it stays put until the redirect.
            if (taken) target_reg <= target_calc;
            if (in_slot_branch || (accept && !sel_ok)) err_reg <= 1'b1;
            if (accept && (cnt_resolved_reg != {CNT_W{1'b1}}))
                cnt_resolved_reg <= cnt_resolved_reg + CNT_W'(1);
            if (taken && (cnt_taken_reg != {CNT_W{1'b1}}))
                cnt_taken_reg <= cnt_taken_reg + CNT_W'(1);
        end
    end

    assign qc_sel          = ex_valid_reg ? ex_sel_reg : SELECT_QC_NE;
    assign redirect_valid  = (state_reg == ST_REDIRECT);
    assign busy            = (state_reg != ST_IDLE);
    assign redirect_target = target_reg;
    assign err             = err_reg;
    assign cnt_resolved    = cnt_resolved_reg;
    assign cnt_taken       = cnt_taken_reg;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: vector table for single branches plus
// hand sequences for stall, delay-slot, reset and saturation corners.
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        id_br_valid = 1'b0;
    logic [5:0]  id_br_sel = 6'h00;
    logic [31:0] id_br_pc = 32'h0;
    logic [15:0] id_br_offset = 16'h0;
    logic        qc_result = 1'b0;
    logic        slot_issued = 1'b0;

    logic [5:0]  qc_sel, qc_sel_s;
    logic        redirect_valid, redirect_valid_s;
    logic [31:0] redirect_target, redirect_target_s;
    logic        busy, busy_s, err, err_s;
    logic [15:0] cnt_resolved, cnt_taken;
    logic [3:0]  cnt_resolved_s, cnt_taken_s;

    int checks = 0;
    int errors = 0;
    int exp_res = 0;
    int exp_tak = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    branch_unit dut (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .id_br_valid(id_br_valid), .id_br_sel(id_br_sel), .id_br_pc(id_br_pc),
        .id_br_offset(id_br_offset), .qc_sel(qc_sel), .qc_result(qc_result),
        .slot_issued(slot_issued), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .busy(busy), .err(err),
        .cnt_resolved(cnt_resolved), .cnt_taken(cnt_taken)
    );

    // Narrow-counter copy on the same stimulus, used to reach saturation quickly.
    branch_unit #(.CNT_W(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .id_br_valid(id_br_valid), .id_br_sel(id_br_sel), .id_br_pc(id_br_pc),
        .id_br_offset(id_br_offset), .qc_sel(qc_sel_s), .qc_result(qc_result),
        .slot_issued(slot_issued), .redirect_valid(redirect_valid_s),
        .redirect_target(redirect_target_s), .busy(busy_s), .err(err_s),
        .cnt_resolved(cnt_resolved_s), .cnt_taken(cnt_taken_s)
    );

    typedef struct {
        logic [5:0]  sel;
        logic [31:0] pc;
        logic [15:0] off;
        logic        qc;
        logic        taken;
        logic [31:0] target;
        logic        err;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        exp_res = 0;
        exp_tak = 0;
        exp_err = 1'b0;
    endtask

    task automatic present(input logic [5:0] sel, input logic [31:0] pc, input logic [15:0] off);
        id_br_valid  = 1'b1;
        id_br_sel    = sel;
        id_br_pc     = pc;
        id_br_offset = off;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        present(v.sel, v.pc, v.off);
        qc_result = v.qc;
        tick();
        id_br_valid = 1'b0;
        check("ex_qc_sel", qc_sel, v.sel);
        tick();
        exp_res++;
        if (v.taken) exp_tak++;
        exp_err = exp_err | v.err;
        check("busy_after_resolve", busy, v.taken);
        check("err", err, exp_err);
        check("cnt_resolved", cnt_resolved, exp_res);
        check("cnt_taken", cnt_taken, exp_tak);
        if (v.taken) begin
            check("target_resolve", redirect_target, v.target);
            check("rv_in_slot", redirect_valid, 1'b0);
            slot_issued = 1'b1;
            tick();
            slot_issued = 1'b0;
            check("rv_pulse", redirect_valid, 1'b1);
            check("target_redirect", redirect_target, v.target);
        end
        tick();
        check("rv_after", redirect_valid, 1'b0);
        check("busy_after", busy, 1'b0);
        $display("vec %0d sel=%h pc=%h off=%h qc=%0b -> taken=%0b target=%h err=%0b",
                 idx, v.sel, v.pc, v.off, v.qc, v.taken, redirect_target, err);
    endtask

    initial begin
        vecs[0] = '{6'h01, 32'h0040_0000, 16'h0004, 1'b1, 1'b1, 32'h0040_0014, 1'b0};
        vecs[1] = '{6'h02, 32'h0040_0100, 16'h0010, 1'b0, 1'b0, 32'h0,         1'b0};
        vecs[2] = '{6'h20, 32'h0000_0000, 16'hFFFE, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0};
        vecs[3] = '{6'h10, 32'h1000_0000, 16'h7FFF, 1'b1, 1'b1, 32'h1002_0000, 1'b0};
        vecs[4] = '{6'h04, 32'h0000_2000, 16'h8000, 1'b0, 1'b0, 32'h0,         1'b0};
        vecs[5] = '{6'h08, 32'hFFFF_FFF0, 16'h0001, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0};
        vecs[6] = '{6'h3F, 32'h0000_3000, 16'h0001, 1'b1, 1'b0, 32'h0,         1'b1};

        // Reset state, observed while reset is still held.
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_rv", redirect_valid, 1'b0);
        check("rst_target", redirect_target, 32'h0);
        check("rst_err", err, 1'b0);
        check("rst_cnt_res", cnt_resolved, 16'h0);
        check("rst_cnt_tak", cnt_taken, 16'h0);
        check("idle_qc_sel", qc_sel, 6'h02);
        do_reset();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Stall in REDIRECT: pulse held three stalled cycles plus one more.
        do_reset();
        present(6'h01, 32'h0000_1000, 16'h0002);
        qc_result = 1'b1;
        tick();
        id_br_valid = 1'b0;
        tick();
        slot_issued = 1'b1;
        tick();
        slot_issued = 1'b0;
        check("stall_rv_enter", redirect_valid, 1'b1);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_rv_held", redirect_valid, 1'b1);
            check("stall_target", redirect_target, 32'h0000_100C);
        end
        stall = 1'b0;
        tick();
        check("stall_rv_last", redirect_valid, 1'b0);
        check("stall_busy_last", busy, 1'b0);
        $display("stall-in-redirect sequence done rv=%0b busy=%0b", redirect_valid, busy);

        // Branch in the delay slot: discarded, err set, original redirect kept.
        do_reset();
        present(6'h01, 32'h0040_0000, 16'h0004);
        qc_result = 1'b1;
        tick();
        present(6'h10, 32'h0050_0000, 16'h0100);
        tick();
        id_br_valid = 1'b0;
        check("ds_busy", busy, 1'b1);
        check("ds_qc_sel", qc_sel, 6'h10);
        slot_issued = 1'b1;
        tick();
        slot_issued = 1'b0;
        check("ds_err", err, 1'b1);
        check("ds_rv", redirect_valid, 1'b1);
        check("ds_target", redirect_target, 32'h0040_0014);
        check("ds_cnt_res", cnt_resolved, 16'd1);
        check("ds_cnt_tak", cnt_taken, 16'd1);
        tick();
        check("ds_idle", busy, 1'b0);
        $display("delay-slot branch sequence done err=%0b target=%h", err, redirect_target);

        // Reset while in SLOT aborts immediately with no pulse.
        do_reset();
        present(6'h01, 32'h0040_0000, 16'h0004);
        tick();
        id_br_valid = 1'b0;
        tick();
        check("slot_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_rv", redirect_valid, 1'b0);
        check("arst_cnt", cnt_resolved, 16'h0);
        check("arst_target", redirect_target, 32'h0);
        slot_issued = 1'b1;
        tick();
        slot_issued = 1'b0;
        check("arst_no_pulse", redirect_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        present(6'h04, 32'h0000_0040, 16'h0001);
        qc_result = 1'b0;
        tick();
        id_br_valid = 1'b0;
        check("first_after_rst", qc_sel, 6'h04);
        tick();
        check("first_cnt_res", cnt_resolved, 16'd1);
        $display("reset-in-slot sequence done busy=%0b cnt_resolved=%0d", busy, cnt_resolved);

        // Saturation using direct IDLE->REDIRECT branches (slot already issued).
        do_reset();
        qc_result = 1'b1;
        for (int n = 0; n < 18; n++) begin
            present(6'h01, 32'h0000_0100, 16'h0000);
            tick();
            id_br_valid = 1'b0;
            slot_issued = 1'b1;
            tick();
            slot_issued = 1'b0;
            check("direct_rv", redirect_valid, 1'b1);
            tick();
        end
        check("sat_small_tak", cnt_taken_s, 4'hF);
        check("sat_small_res", cnt_resolved_s, 4'hF);
        check("wide_tak", cnt_taken, 16'd18);
        check("wide_res", cnt_resolved, 16'd18);
        $display("saturation sequence done small_taken=%h wide_taken=%0d", cnt_taken_s, cnt_taken);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter CNT_W, 16, width of the saturating statistics counters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  pipeline stall; freezes all state when 1.
REQ-005 id_br_valid  input  1  ID stage presents a conditional branch this cycle.
REQ-006 id_br_sel  input  6  compare selector, using the shared select_qc_* encodings.
REQ-007 id_br_pc  input  32  byte address of the branch instruction.
REQ-008 id_br_offset  input  16  signed word offset from the instruction immediate.
REQ-009 qc_sel  output  6  compare selector driven to the quick-compare block.
REQ-010 qc_result  input  1  compare result returned by the quick-compare block, same cycle.
REQ-011 slot_issued  input  1  one-cycle pulse when the delay-slot instruction leaves ID.
REQ-012 redirect_valid  output  1  one-cycle pulse: fetch loads redirect_target.
REQ-013 redirect_target  output  32  branch target address.
REQ-014 busy  output  1  taken branch pending (state not IDLE); ID must not issue another branch.
REQ-015 err  output  1  sticky error flag.
REQ-016 cnt_resolved, cnt_taken  output  CNT_W each  resolved and taken branch counts.

Function
REQ-017 When stall=0 and id_br_valid=1, the unit SHALL latch sel, pc and offset into the EX register; when id_br_valid=0, it SHALL clear the EX valid bit.
REQ-018 qc_sel SHALL equal the latched selector while EX is valid, and select_qc_ne otherwise.
REQ-019 The unit SHALL compute target = pc + 4 + (sign_extend(offset) << 2), modulo 2^32, and register it in the resolving cycle.
REQ-020 Resolution SHALL take one cycle: an EX-valid branch resolves in the cycle it sits in EX with stall=0.
REQ-021 A selector outside the six defined encodings SHALL set err and SHALL resolve as not-taken, ignoring qc_result.
REQ-022 FSM states: IDLE, SLOT, REDIRECT.
REQ-023 IDLE -> SLOT on a resolved taken branch; not-taken stays in IDLE.
REQ-024 SLOT -> REDIRECT on slot_issued=1 with stall=0.
REQ-025 If slot_issued was already asserted in the resolving cycle, IDLE -> REDIRECT directly.
REQ-026 REDIRECT SHALL assert redirect_valid for exactly one non-stalled cycle, then return to IDLE.
REQ-027 Under stall, redirect_valid SHALL be held and the state SHALL be held.
REQ-028 A branch arriving in EX while the state is SLOT or REDIRECT (branch in delay slot) SHALL set err, SHALL be discarded, and SHALL NOT be counted.
REQ-029 cnt_resolved SHALL increment on every accepted resolution.
REQ-030 cnt_taken SHALL increment on every accepted taken resolution.
REQ-031 Both counters SHALL saturate at all-ones.
REQ-032 redirect_target SHALL remain stable from the resolving cycle through the REDIRECT cycle.

Reset
REQ-033 Asserting reset_n low SHALL immediately force:
- state=IDLE
- EX valid=0
- redirect_valid=0
- redirect_target=0
- busy=0
- err=0
- both counters=0
REQ-034 Reset asserted mid-branch (in SLOT or REDIRECT) SHALL abort the branch with no redirect pulse.
REQ-035 After reset_n is released, the first acceptable branch SHALL be on the following rising edge.

Structure
REQ-036 The select_qc_* encodings and the FSM state encodings SHALL live in the shared mips.h definitions.
REQ-037 The target adder SHALL be one sub-module, br_target_add (32-bit pc, 16-bit offset -> 32-bit target).
REQ-038 The quick-compare block SHALL remain a separate instance at CPU level; branch_unit SHALL NOT duplicate the compare logic.

Verification
REQ-039 BEQ taken:
- stimulus: pc=0x00400000, offset=0x0004, qc_result=1, slot_issued one cycle later
- response: a single redirect_valid pulse with target 0x00400014; cnt_taken=1
REQ-040 BNE not-taken:
- stimulus: qc_result=0
- response: no redirect; cnt_resolved=1; cnt_taken=0; busy stays 0
REQ-041 Negative offset and wrap:
- stimulus: pc=0x00000000, offset=0xFFFE
- response: target 0xFFFFFFFC
REQ-042 Stall in REDIRECT:
- stimulus: stall=1 for 3 cycles during REDIRECT
- response: redirect_valid held for those 3 cycles, then exactly one more non-stalled cycle, then IDLE
REQ-043 Error cases:
- stimulus: undefined selector 6'h3F
- response: err=1, not-taken
- stimulus: a branch in the delay slot
- response: err=1, the branch is discarded, and the original redirect still occurs
REQ-044 Reset and saturation:
- stimulus: reset_n asserted while in SLOT
- response: immediate IDLE with no pulse
- stimulus: 2^CNT_W+2 taken branches
- response: cnt_taken=0xFFFF
